// File: rtl/fx_pkg.sv
// fx_pkg: shared constants and width helpers for the fixed-point converters.
//   FX_RND_*  : rounding mode selectors (truncate, half-up, half-even)
//   FX_OVF_*  : overflow mode selectors (wrap, saturate)
//   fx_shift     : fractional-bit shift from input to output format
//   fx_mid_width : width of the quantised intermediate (one spare bit when
//                  LSBs are dropped so the rounding carry cannot be lost)
package fx_pkg;

    localparam int FX_RND_TRUNC     = 0;
    localparam int FX_RND_HALF_UP   = 1;
    localparam int FX_RND_HALF_EVEN = 2;

    localparam int FX_OVF_WRAP = 0;
    localparam int FX_OVF_SAT  = 1;

    function automatic int fx_shift(input int in_frac, input int out_frac);
        return in_frac - out_frac;
    endfunction

    function automatic int fx_mid_width(input int in_w, input int in_frac, input int out_frac);
        int sh;
        sh = in_frac - out_frac;
        return (sh > 0) ? (in_w - sh + 1) : (in_w - sh);
    endfunction

endpackage

// File: rtl/fx_quant_round.sv
// fx_quant_round: combinational re-quantisation of a signed fixed-point word.
//   din  : signed input, IF fractional bits
//   dout : signed intermediate, OF fractional bits, width fx_mid_width()
// Left shifts pad zero LSBs; right shifts floor and then optionally add
// the rounding increment selected by ROUND_MODE.
module fx_quant_round
    import fx_pkg::*;
#(
    parameter int IW         = 13,
    parameter int IF         = 8,
    parameter int OF         = 8,
    parameter int ROUND_MODE = FX_RND_TRUNC,
    localparam int MW        = fx_mid_width(IW, IF, OF)
) (
    input  logic [IW-1:0]        din,
    output logic signed [MW-1:0] dout
);

    localparam int SH = fx_shift(IF, OF);

    if (ROUND_MODE < 0 || ROUND_MODE > 2) begin : g_bad_round
        $error("fx_quant_round: ROUND_MODE must be 0, 1 or 2");
    end

    if (SH <= 0) begin : g_left
        localparam int LS = -SH;
        logic signed [MW-1:0] ext;
        always_comb begin
            ext  = MW'($signed(din));
            dout = ext <<< LS;
        end
    end else begin : g_right
        // Sticky covers bits below the guard; for SH==1 there are none.
        localparam int SB = (SH > 1) ? SH - 1 : 1;
        logic signed [IW-1:0] sdin;
        logic signed [MW-1:0] fl;
        logic [MW-1:0]        inc_v;
        logic                 guard;
        logic                 sticky;
        logic                 inc;
        always_comb begin
            sdin   = $signed(din);
            fl     = MW'(sdin >>> SH);
            guard  = din[SH-1];
            sticky = (SH > 1) ? (|din[SB-1:0]) : 1'b0;
            case (ROUND_MODE)
                FX_RND_HALF_UP:   inc = guard;
                FX_RND_HALF_EVEN: inc = guard & (sticky | fl[0]);
                default:          inc = 1'b0;
            endcase
            inc_v    = '0;
            inc_v[0] = inc;
            dout     = fl + $signed(inc_v);
        end
    end

endmodule

// File: rtl/fx_match_pipe.sv
// fx_match_pipe: pipelined fixed-point format converter with valid/ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_valid/i_ready   : input handshake, i_data is Q(IW-IF).IF
//   o_valid/o_ready   : output handshake, o_data is Q(OW-OF).OF
//   o_ovf             : current output sample overflowed
//   ovf_cnt, clr_cnt  : saturating overflow count, synchronous clear
// Stage 1 quantises, stage 2 range-checks, stages 3..STAGES delay. A single
// enable stalls the whole pipe whenever the output is held.
module fx_match_pipe
    import fx_pkg::*;
#(
    parameter int IW         = 13,
    parameter int IF         = 8,
    parameter int OW         = 14,
    parameter int OF         = 8,
    parameter int ROUND_MODE = FX_RND_TRUNC,
    parameter int SAT_MODE   = FX_OVF_SAT,
    parameter int STAGES     = 3,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [IW-1:0]    i_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [OW-1:0]    o_data,
    output logic             o_ovf,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             clr_cnt
);

    localparam int MW = fx_mid_width(IW, IF, OF);

    if (STAGES < 2 || ROUND_MODE < 0 || ROUND_MODE > 2 ||
        SAT_MODE < 0 || SAT_MODE > 1 || CNT_W < 1) begin : g_bad_param
        $error("fx_match_pipe: illegal parameter combination");
    end

    logic                 en;
    logic signed [MW-1:0] q_mid;
    logic                 s1_vld;
    logic signed [MW-1:0] s1_mid;
    logic [OW-1:0]        ov_data;
    logic                 ov_flag;

    logic                 d_vld  [2:STAGES];
    logic [OW-1:0]        d_data [2:STAGES];
    logic                 d_ovf  [2:STAGES];

    always_comb begin
        en      = !o_valid || o_ready;
        i_ready = en;
    end

    fx_quant_round #(
        .IW         (IW),
        .IF         (IF),
        .OF         (OF),
        .ROUND_MODE (ROUND_MODE)
    ) u_quant (
        .din  (i_data),
        .dout (q_mid)
    );

    if (MW <= OW) begin : g_fit
        always_comb begin
            ov_data = OW'(s1_mid);
            ov_flag = 1'b0;
        end
    end else begin : g_clip
        // Value fits iff every bit from the top down to the OW sign bit agrees.
        localparam int HW = MW - OW + 1;
        logic [HW-1:0] top_bits;
        always_comb begin
            top_bits = s1_mid[MW-1:OW-1];
            ov_flag  = !((top_bits == '0) || (top_bits == '1));
            if (ov_flag && SAT_MODE == FX_OVF_SAT)
                ov_data = s1_mid[MW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            else
                ov_data = s1_mid[OW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_mid <= '0;
            for (int unsigned k = 2; k <= STAGES; k++) begin
                d_vld[k]  <= 1'b0;
                d_data[k] <= '0;
                d_ovf[k]  <= 1'b0;
            end
        end else if (en) begin
            s1_vld    <= i_valid;
            s1_mid    <= q_mid;
            d_vld[2]  <= s1_vld;
            d_data[2] <= ov_data;
            d_ovf[2]  <= ov_flag & s1_vld;
            for (int unsigned k = 3; k <= STAGES; k++) begin
                d_vld[k]  <= d_vld[k-1];
                d_data[k] <= d_data[k-1];
                d_ovf[k]  <= d_ovf[k-1];
            end
        end
    end

    always_comb begin
        o_valid = d_vld[STAGES];
        o_data  = d_data[STAGES];
        o_ovf   = d_ovf[STAGES];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt <= '0;
        else if (clr_cnt)
            ovf_cnt <= '0;
        else if (o_valid && o_ready && o_ovf && (ovf_cnt != '1))
            ovf_cnt <= ovf_cnt + 1'b1;
    end

endmodule
